rx_ctrl_demux: RTL and testbench

Receive-side counterpart of the transmit control-symbol mux. It accepts a byte stream with a per-byte K (control) flag and classifies each K-symbol into the same 4-bit code space the transmitter uses on its select input. It frames TLPs (STP…END/EDB) and DLLPs (SDP…END), strips framing, PAD and ordered sets, and delivers payload bytes with start/end markers. It sits between the lane de-scrambler/decoder output and the link-layer receive logic.

---
 rtl/rx_ctrl_demux.sv | 213 +++++++++++++++++++++
 tb/tb_rx_ctrl_demux.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_ctrl_demux.sv
`default_nettype none
// ============================================================================
// rx_ctrl_demux : receive-side K-symbol classifier and TLP/DLLP deframer.
//                 Strips framing, PAD and ordered sets; emits payload bytes.
// Revision      : 1.0
// ============================================================================
module rx_ctrl_demux #(
  parameter int MAX_LEN = 64
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic [7:0] data_in,
  input  logic       k_in,
  input  logic       valid_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       sop,
  output logic       eop,
  output logic       pkt_type,
  output logic       nullified,
  output logic [3:0] sym_code,
  output logic       os_det,
  output logic [1:0] os_kind,
  output logic       err
);
  localparam int c_LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [c_LEN_W-1:0] c_MAX_LEN = c_LEN_W'(MAX_LEN);

  localparam logic [3:0] c_DATA = 4'd0, c_COM = 4'd1, c_PAD = 4'd2, c_SKP = 4'd3,
                         c_STP  = 4'd4, c_SDP = 4'd5, c_END = 4'd6, c_EDB = 4'd7,
                         c_FTS  = 4'd8, c_IDL = 4'd9, c_UNK = 4'd15;

  localparam logic [1:0] c_S_IDLE = 2'd0, c_S_OS = 2'd1, c_S_TLP = 2'd2, c_S_DLLP = 2'd3;

  logic [1:0]         r_state, w_state_nxt, w_idle_tgt;
  logic [1:0]         r_os_cnt, r_os_kind, w_sym_kind, w_os_kind;
  logic [7:0]         r_hold;
  logic               r_hold_vld, r_first, r_type;
  logic [c_LEN_W-1:0] r_len;
  logic [3:0]         w_code;
  logic               w_is_os, w_in_pkt, w_idle_proc, w_overflow, w_accept;
  logic               w_emit, w_eop, w_null, w_err, w_os_det;

  always_comb begin
    w_code = c_DATA;
    if (k_in) begin
      case (data_in)
        8'hBC:   w_code = c_COM;
        8'hF7:   w_code = c_PAD;
        8'h1C:   w_code = c_SKP;
        8'hFB:   w_code = c_STP;
        8'h5C:   w_code = c_SDP;
        8'hFD:   w_code = c_END;
        8'hFE:   w_code = c_EDB;
        8'h3C:   w_code = c_FTS;
        8'h7C:   w_code = c_IDL;
        default: w_code = c_UNK;
      endcase
    end
  end

  assign w_is_os     = (w_code == c_SKP) || (w_code == c_FTS) || (w_code == c_IDL);
  assign w_sym_kind  = (w_code == c_FTS) ? 2'd1 : (w_code == c_IDL) ? 2'd2 : 2'd0;
  assign w_in_pkt    = (r_state == c_S_TLP) || (r_state == c_S_DLLP);
  // A symbol that ends an ordered set is handled exactly as it would be in IDLE.
  assign w_idle_proc = (r_state == c_S_IDLE) || ((r_state == c_S_OS) && !w_is_os);
  assign w_overflow  = (r_len == c_MAX_LEN);
  assign w_accept    = w_in_pkt && (w_code == c_DATA) && !w_overflow;

  always_comb begin
    case (w_code)
      c_COM:   w_idle_tgt = c_S_OS;
      c_STP:   w_idle_tgt = c_S_TLP;
      c_SDP:   w_idle_tgt = c_S_DLLP;
      default: w_idle_tgt = c_S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) r_state <= c_S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (valid_in) begin
      if (w_idle_proc)
        w_state_nxt = w_idle_tgt;
      else if (r_state == c_S_OS) begin
        if (r_os_cnt == 2'd2) w_state_nxt = c_S_IDLE;
      end else if (!w_accept)
        w_state_nxt = c_S_IDLE;
    end
  end

  always_comb begin
    w_emit    = 1'b0;
    w_eop     = 1'b0;
    w_null    = 1'b0;
    w_err     = 1'b0;
    w_os_det  = 1'b0;
    w_os_kind = 2'd3;
    if (valid_in) begin
      if (r_state == c_S_OS) begin
        if (w_is_os) begin
          if ((r_os_cnt != 2'd0) && (w_sym_kind != r_os_kind)) w_err = 1'b1;
          if (r_os_cnt == 2'd2) begin
            w_os_det  = 1'b1;
            w_os_kind = r_os_kind;
          end
        end else begin
          w_os_det  = 1'b1;
          w_os_kind = (r_os_cnt == 2'd0) ? 2'd3 : r_os_kind;
        end
      end
      if (w_idle_proc) begin
        case (w_code)
          c_COM, c_STP, c_SDP, c_PAD, c_IDL: w_err = 1'b0;
          default:                           w_err = 1'b1;
        endcase
      end else if (w_in_pkt) begin
        case (w_code)
          c_DATA: begin
            if (w_overflow) w_err  = 1'b1;
            else            w_emit = r_hold_vld;
          end
          c_END: begin
            w_emit = r_hold_vld;
            w_eop  = r_hold_vld;
            w_err  = !r_hold_vld;
          end
          c_EDB: begin
            w_emit = r_hold_vld && (r_state == c_S_TLP);
            w_eop  = w_emit;
            w_null = w_emit;
            w_err  = !w_emit;
          end
          default: w_err = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_hold     <= 8'd0;
      r_hold_vld <= 1'b0;
      r_first    <= 1'b0;
      r_type     <= 1'b0;
      r_len      <= '0;
      r_os_cnt   <= 2'd0;
      r_os_kind  <= 2'd0;
    end else if (valid_in) begin
      if (w_accept) begin
        r_hold     <= data_in;
        r_hold_vld <= 1'b1;
        r_len      <= r_len + 1'b1;
        if (w_emit) r_first <= 1'b0;
      end else if (w_idle_proc && ((w_code == c_STP) || (w_code == c_SDP))) begin
        r_hold_vld <= 1'b0;
        r_len      <= '0;
        r_first    <= 1'b1;
        r_type     <= (w_code == c_SDP);
      end else if ((w_state_nxt != c_S_TLP) && (w_state_nxt != c_S_DLLP)) begin
        r_hold_vld <= 1'b0;
        r_len      <= '0;
      end
      if (w_idle_proc && (w_code == c_COM))
        r_os_cnt <= 2'd0;
      else if ((r_state == c_S_OS) && w_is_os) begin
        r_os_cnt <= (r_os_cnt == 2'd3) ? r_os_cnt : r_os_cnt + 2'd1;
        if (r_os_cnt == 2'd0) r_os_kind <= w_sym_kind;
      end
    end
  end

  // Beat markers and pulses are single-cycle; payload fields hold their last value.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= 8'd0;
      valid_out <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      pkt_type  <= 1'b0;
      nullified <= 1'b0;
      sym_code  <= 4'd0;
      os_det    <= 1'b0;
      os_kind   <= 2'd0;
      err       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      os_det    <= 1'b0;
      err       <= 1'b0;
      if (valid_in) begin
        sym_code  <= w_code;
        err       <= w_err;
        os_det    <= w_os_det;
        valid_out <= w_emit;
        sop       <= w_emit && r_first;
        eop       <= w_eop;
        if (w_os_det) os_kind <= w_os_kind;
        if (w_emit) begin
          data_out  <= r_hold;
          pkt_type  <= r_type;
          nullified <= w_null;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_rx_ctrl_demux.sv
`default_nettype none
// Bench for rx_ctrl_demux: randomized symbol streams against a packet-level
// reference model, plus directed sequences with literal expectations.
module tb_rx_ctrl_demux;
  localparam int ML = 4;

  logic       clk = 1'b0, reset_L = 1'b0;
  logic [7:0] data_in = 8'd0;
  logic       k_in = 1'b0, valid_in = 1'b0;
  logic [7:0] data_out;
  logic       valid_out, sop, eop, pkt_type, nullified, os_det, err;
  logic [3:0] sym_code;
  logic [1:0] os_kind;

  rx_ctrl_demux #(.MAX_LEN(ML)) dut (
    .clk(clk), .reset_L(reset_L), .data_in(data_in), .k_in(k_in), .valid_in(valid_in),
    .data_out(data_out), .valid_out(valid_out), .sop(sop), .eop(eop), .pkt_type(pkt_type),
    .nullified(nullified), .sym_code(sym_code), .os_det(os_det), .os_kind(os_kind), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_mode = 0, m_osn = 0, m_osk = 0, m_type = 0, m_emitted = 0, m_dcount = 0;
  logic [7:0] m_q[$];
  logic       e_valid = 0, e_sop = 0, e_eop = 0, e_null = 0, e_type = 0, e_err = 0, e_os = 0;
  logic [7:0] e_data = 0;
  logic [1:0] e_kind = 0;
  logic [3:0] e_code = 0;

  function automatic int decode(input logic k, input logic [7:0] d);
    if (!k) return 0;
    case (d)
      8'hBC: return 1;  8'hF7: return 2;  8'h1C: return 3;
      8'hFB: return 4;  8'h5C: return 5;  8'hFD: return 6;
      8'hFE: return 7;  8'h3C: return 8;  8'h7C: return 9;
      default: return 15;
    endcase
  endfunction

  task automatic m_emit(input logic [7:0] b, input bit last, input bit nul);
    e_valid = 1; e_data = b; e_sop = (m_emitted == 0); e_eop = last;
    e_null = nul; e_type = (m_type != 0); m_emitted++;
  endtask

  task automatic m_idle(input int c);
    m_mode = 0;
    case (c)
      1: begin m_mode = 1; m_osn = 0; end
      4, 5: begin
        m_mode = (c == 4) ? 2 : 3; m_type = (c == 5); m_q.delete();
        m_emitted = 0; m_dcount = 0;
      end
      2, 9: ;
      default: e_err = 1;
    endcase
  endtask

  task automatic m_step();
    int c, k;
    bit idle_like;
    e_valid = 0; e_sop = 0; e_eop = 0; e_err = 0; e_os = 0;
    if (!reset_L) begin
      m_mode = 0; m_q.delete();
      e_data = 0; e_null = 0; e_type = 0; e_kind = 0; e_code = 0;
      return;
    end
    if (!valid_in) return;
    c = decode(k_in, data_in);
    e_code = c[3:0];
    idle_like = 0;
    if (m_mode == 0) idle_like = 1;
    else if (m_mode == 1) begin
      if (c == 3 || c == 8 || c == 9) begin
        k = (c == 3) ? 0 : (c == 8) ? 1 : 2;
        if (m_osn == 0) m_osk = k;
        else if (k != m_osk) e_err = 1;
        m_osn++;
        if (m_osn == 3) begin e_os = 1; e_kind = m_osk[1:0]; m_mode = 0; end
      end else begin
        e_os = 1; e_kind = (m_osn == 0) ? 2'd3 : m_osk[1:0]; idle_like = 1;
      end
    end else begin
      if (c == 0) begin
        m_dcount++;
        if (m_dcount > ML) begin e_err = 1; m_mode = 0; m_q.delete(); end
        else begin
          m_q.push_back(data_in);
          if (m_q.size() > 1) m_emit(m_q.pop_front(), 0, 0);
        end
      end else if (c == 6 || (c == 7 && m_mode == 2)) begin
        if (m_q.size() == 0) e_err = 1;
        else m_emit(m_q.pop_front(), 1, c == 7);
        m_mode = 0; m_q.delete();
      end else begin
        e_err = 1; m_mode = 0; m_q.delete();
      end
    end
    if (idle_like) m_idle(c);
  endtask

  // ---------------- compare + observation log ----------------
  logic [11:0] obs[$];
  int n_err = 0, n_os = 0;
  logic [1:0] last_kind = 0;

  always @(posedge clk) begin
    m_step();
    #1;
    chk("valid_out", valid_out, e_valid);
    if (e_valid) begin
      chk("data_out", data_out, e_data);
      chk("sop", sop, e_sop);
      chk("eop", eop, e_eop);
      chk("pkt_type", pkt_type, e_type);
      if (e_eop) chk("nullified", nullified, e_null);
    end
    chk("err", err, e_err);
    chk("os_det", os_det, e_os);
    if (e_os) chk("os_kind", os_kind, e_kind);
    chk("sym_code", sym_code, e_code);
    if (valid_out) obs.push_back({nullified, pkt_type, eop, sop, data_out});
    if (err) n_err++;
    if (os_det) begin n_os++; last_kind = os_kind; end
  end

  // ---------------- stimulus ----------------
  task automatic sym(input bit k, input logic [7:0] d, input int gaps);
    repeat (gaps) begin @(negedge clk); valid_in = 0; end
    @(negedge clk); valid_in = 1; k_in = k; data_in = d;
  endtask

  task automatic flush();
    @(negedge clk); valid_in = 0; k_in = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic clr();
    obs.delete(); n_err = 0; n_os = 0;
  endtask

  function automatic int rgap();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
  endfunction

  logic [7:0] ks[9] = '{8'hBC, 8'hF7, 8'h1C, 8'hFB, 8'h5C, 8'hFD, 8'hFE, 8'h3C, 8'h7C};
  logic [7:0] oss[3] = '{8'h1C, 8'h3C, 8'h7C};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_data_out", data_out, 0);
    chk("rst_valid_out", valid_out, 0);
    chk("rst_sym_code", sym_code, 0);
    chk("rst_err_osdet", {err, os_det, os_kind}, 0);
    reset_L = 1;
    @(negedge clk);

    // Plain TLP
    clr();
    sym(1, 8'hFB, 0); sym(0, 8'h11, 0); sym(0, 8'h22, 0); sym(0, 8'h33, 0); sym(1, 8'hFD, 0);
    flush();
    chk("tlp_beats", obs.size(), 3);
    chk("tlp_b0", obs[0], 12'h111);
    chk("tlp_b1", obs[1], 12'h022);
    chk("tlp_b2", obs[2], 12'h233);
    chk("tlp_err", n_err, 0);

    // DLLP with bubbles
    clr();
    sym(1, 8'h5C, 2); sym(0, 8'hAA, 3); sym(1, 8'hFD, 2);
    flush();
    chk("dllp_beats", obs.size(), 1);
    chk("dllp_b0", obs[0], 12'h7AA);

    // SKP ordered set then nullified TLP
    clr();
    sym(1, 8'hBC, 0); sym(1, 8'h1C, 0); sym(1, 8'h1C, 0); sym(1, 8'h1C, 0);
    sym(1, 8'hFB, 0); sym(0, 8'h01, 0); sym(1, 8'hFE, 0);
    flush();
    chk("os_count", n_os, 1);
    chk("os_kind_skp", last_kind, 0);
    chk("edb_beat", obs[0], 12'hB01);
    chk("edb_err", n_err, 0);

    // Zero-length and bad-symbol abort
    clr();
    sym(1, 8'hFB, 0); sym(1, 8'hFD, 0);
    sym(1, 8'hFB, 0); sym(0, 8'h05, 0); sym(1, 8'hF7, 0);
    flush();
    chk("abort_errs", n_err, 2);
    chk("abort_beats", obs.size(), 0);

    // Length overflow then a normal DLLP
    clr();
    sym(1, 8'hFB, 0);
    for (int i = 1; i <= 5; i++) sym(0, 8'(i), 0);
    sym(1, 8'h5C, 0); sym(0, 8'h7E, 0); sym(1, 8'hFD, 0);
    flush();
    chk("ovf_errs", n_err, 1);
    chk("ovf_beats", obs.size(), 4);
    chk("ovf_b0", obs[0], 12'h101);
    chk("ovf_b2", obs[2], 12'h003);
    chk("ovf_dllp", obs[3], 12'h77E);

    // Asynchronous reset mid-packet
    sym(1, 8'hFB, 0); sym(0, 8'h10, 0); sym(0, 8'h20, 0);
    @(negedge clk); valid_in = 0;
    #2 reset_L = 0;
    #1;
    chk("arst_valid_out", valid_out, 0);
    chk("arst_data_out", data_out, 0);
    chk("arst_sym_code", sym_code, 0);
    @(negedge clk); reset_L = 1;
    clr();
    sym(1, 8'hFD, 0);
    flush();
    chk("arst_end_err", n_err, 1);
    chk("arst_no_eop", obs.size(), 0);

    // Randomized traffic
    for (int s = 0; s < 500; s++) begin
      int r, n;
      r = $urandom_range(0, 9);
      if (r <= 3) begin
        sym(1, $urandom_range(0, 1) ? 8'hFB : 8'h5C, rgap());
        n = $urandom_range(0, ML + 2);
        for (int i = 0; i < n; i++) sym(0, 8'($urandom), rgap());
        sym(1, ($urandom_range(0, 3) == 0) ? 8'hFE : 8'hFD, rgap());
      end else if (r <= 5) begin
        int o;
        o = $urandom_range(0, 2);
        sym(1, 8'hBC, rgap());
        n = $urandom_range(0, 4);
        for (int i = 0; i < n; i++)
          sym(1, ($urandom_range(0, 4) == 0) ? oss[$urandom_range(0, 2)] : oss[o], rgap());
      end else if (r == 6) begin
        sym(1, $urandom_range(0, 1) ? 8'hF7 : 8'h7C, rgap());
      end else if (r == 7) begin
        if ($urandom_range(0, 1)) sym(1, ks[$urandom_range(0, 8)], rgap());
        else sym($urandom_range(0, 1) != 0, 8'($urandom), rgap());
      end else if (r == 8) begin
        sym(1, 8'hFB, rgap());
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) sym(0, 8'($urandom), rgap());
        sym(1, ks[$urandom_range(0, 8)], rgap());
      end else begin
        @(negedge clk); valid_in = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk); valid_in = 0;
        #2 reset_L = 0;
        @(negedge clk); reset_L = 1;
      end
    end
    flush();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
